dm_sub_word: RTL
================

# dm_sub_word

Parametrised data memory for the single-cycle/pipelined MIPS core, replacing the word-only DM. It supports byte, halfword and word stores through byte-lane merging, and signed or unsigned sub-word loads with a registered 1-cycle read. It flags misaligned and out-of-range accesses, and zero-fills the whole array with a sweep state machine after reset. It sits in the MEM stage between the ALU address output and the writeback mux.

## Interface
- DEPTH, 3072: number of 32-bit words.
- AW, 12: word-index width; must satisfy 2^AW >= DEPTH.
- BASE, 32'h0000_0000: byte address of word 0.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- add  in  32  byte address.
- data  in  32  store data; the low byte or halfword is used for sub-word stores.
- memW  in  1  store request.
- memR  in  1  load request.
- op  in  3  access size and sign: W=0, H=1, HU=2, B=3, BU=4; other codes are illegal.
- pc  in  32  PC of the requesting instruction, used for the write log.
- rdata  out  32  extended load result, registered.
- rvalid  out  1  rdata is valid this cycle.
- busy  out  1  clear sweep in progress; requests are ignored.
- exc_adel  out  1  load address error (misaligned, out of range, or illegal op).
- exc_ades  out  1  store address error (same conditions).

## Operation
- Word index idx = (add - BASE) >> 2. The access is in range when add >= BASE and idx < DEPTH.
- Alignment rules:
  - W requires add[1:0] = 0.
  - H and HU require add[0] = 0.
  - B and BU are always aligned.
- Error outputs:
  - exc_ades = memW & ~busy & (misaligned | out of range | illegal op). A flagged store writes nothing.
  - exc_adel = memR & ~memW & ~busy & (same condition). A flagged load produces rvalid=1 with rdata=0.
- Stores:
  - Byte enable for B is 1 << add[1:0].
  - Byte enable for H is 4'b0011 << add[1:0].
  - W enables all four lanes.
  - Lanes are filled from the data byte or halfword replicated across the word. Only enabled lanes change.
- Loads:
  - The selected lane is shifted down by add[1:0].
  - B and H are sign-extended; BU and HU are zero-extended; W passes through.
- memW and memR together: the store wins and the load is dropped (rvalid=0). exc_adel stays 0.
- Clear FSM states:
  - CLEAR: write 0 to word cnt, then cnt++. When cnt = DEPTH-1, go to IDLE.
  - IDLE: serve requests.
- Reset asynchronously forces CLEAR with cnt=0, including mid-sweep or mid-access. A store pending on that edge is lost.

## Timing
- Reset values: rdata=0, rvalid=0, busy=1, exc_adel=0, exc_ades=0, cnt=0, state=CLEAR.
- The sweep takes exactly DEPTH cycles after reset deasserts. busy falls on the edge that writes word DEPTH-1.
- Stores commit on the rising edge of the request cycle.
- Load latency is 1:
  - A request in cycle N gives rdata/rvalid in cycle N+1.
  - rvalid is high for one cycle per accepted load.
  - rdata holds its value when rvalid=0.
- A load in cycle N+1 returns data written by a store in cycle N.
- The exception outputs are combinational from the request inputs in the same cycle, so the pipeline can flush before the commit edge.
- Requests while busy=1: no write, rvalid stays 0, no exception.

## Configuration
- DM_WRITE_LOG_EN defined: each committed store prints "@%h: *%h <= %h" with pc, the word-aligned byte address, and the full merged word after the write. Sweep writes are not logged.
- DM_WRITE_LOG_EN undefined: no $display is compiled in, and behaviour is otherwise identical.

## Structure
- Package dm_pkg holds:
  - the op encodings DM_OP_W/H/HU/B/BU;
  - the state typedef {CLEAR, IDLE};
  - the default DEPTH/AW constants.
- Sub-module dm_load_ext is a combinational lane select plus extension. Inputs: 32-bit word, offset[1:0], op. Output: 32-bit result. It is instantiated on the registered read path.
- The top level holds the array, the byte-enable merge, the clear FSM and the error decode.

## Test plan
- Reset, then hold idle → busy=1 for exactly 3072 cycles, then 0. A lw of 0x0 returns 0 with rvalid one cycle after the request.
- sw 0x1234_5678 to 0x10; sb 0xAB to 0x11 → lw 0x10 returns 0x1234_AB78. lb 0x11 returns 0xFFFF_FFAB. lbu 0x11 returns 0x0000_00AB.
- sh 0x8001 to 0x22 → lw 0x20 returns 0x8001_0000. lh 0x22 returns 0xFFFF_8001. lhu 0x22 returns 0x0000_8001.
- sw to 0x06, lh from 0x03, and lw of byte address 3072*4 → exc_ades/exc_adel high in the request cycle. Memory is unchanged; the loads return rdata=0 with rvalid=1.
- Assert reset in cycle 100 of the sweep and during a pending sw → the sweep restarts at cnt=0, the store is not committed, and busy lasts a further 3072 cycles.
- With DM_WRITE_LOG_EN, sw 0xDEAD_BEEF to 0x40 with pc 0x3000 → the log shows "@00003000: *00000040 <= deadbeef". Without the macro, no output.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the sub-word data memory: op encodings, clear FSM state, defaults.
package dm_pkg;
  localparam logic [2:0] DM_OP_W  = 3'd0;
  localparam logic [2:0] DM_OP_H  = 3'd1;
  localparam logic [2:0] DM_OP_HU = 3'd2;
  localparam logic [2:0] DM_OP_B  = 3'd3;
  localparam logic [2:0] DM_OP_BU = 3'd4;

  localparam int DM_DEPTH  = 3072;
  localparam int DM_AW     = 12;
  localparam int NUM_LANES = 4;

  typedef enum logic {CLEAR, IDLE} dm_state_e;
endpackage

// File: rtl/dm_load_ext.sv
// Lane select and sign/zero extension for sub-word loads (combinational).
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] result
);
  logic [31:0] sh;

  assign sh = word >> {offset, 3'b000};

  always_comb begin
    result = word;
    case (op)
      DM_OP_H:  result = {{16{sh[15]}}, sh[15:0]};
      DM_OP_HU: result = {16'h0, sh[15:0]};
      DM_OP_B:  result = {{24{sh[7]}}, sh[7:0]};
      DM_OP_BU: result = {24'h0, sh[7:0]};
      default:  result = word;
    endcase
  end
endmodule

// File: rtl/dm_sub_word.sv
// Byte/half/word data memory with registered sub-word loads, address checks and post-reset clear sweep.
// Optional store trace: define DM_WRITE_LOG_EN.
module dm_sub_word
  import dm_pkg::*;
#(
  parameter int          DEPTH = DM_DEPTH,
  parameter int          AW    = DM_AW,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] add,
  input  logic [31:0] data,
  input  logic        memW,
  input  logic        memR,
  input  logic [2:0]  op,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        exc_adel,
  output logic        exc_ades
);
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  dm_state_e state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic [31:0]               off;
  logic [AW-1:0]             idx;
  logic                      oor, mis, ill, err;
  logic                      st_acc, ld_acc;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wd, cur, merged, wr_word;
  logic [AW-1:0]             wr_idx;
  logic                      wr_en;
  logic [31:0]               ld_word;

  assign off = add - BASE;
  assign idx = off[AW+1:2];
  assign oor = (add < BASE) || ({2'b00, off[31:2]} >= 32'(DEPTH));
  assign ill = op > DM_OP_BU;

  always_comb begin
    mis = 1'b0;
    case (op)
      DM_OP_W:           mis = add[1:0] != 2'b00;
      DM_OP_H, DM_OP_HU: mis = add[0];
      default:           mis = 1'b0;
    endcase
  end

  assign err      = oor | mis | ill;
  assign busy     = state == CLEAR;
  assign exc_ades = memW & ~busy & err;
  assign exc_adel = memR & ~memW & ~busy & err;
  assign st_acc   = memW & ~busy & ~err;
  assign ld_acc   = memR & ~memW & ~busy;

  always_comb begin
    be = 4'b1111;
    wd = data;
    case (op)
      DM_OP_H, DM_OP_HU: begin
        be = 4'b0011 << add[1:0];
        wd = {2{data[15:0]}};
      end
      DM_OP_B, DM_OP_BU: begin
        be = 4'b0001 << add[1:0];
        wd = {4{data[7:0]}};
      end
      default: ;
    endcase
  end

  assign cur = mem[idx];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged[g] = be[g] ? wd[g] : cur[g];
  end

  // Single write port shared by the clear sweep and stores; reset blocks both.
  assign wr_en   = ~reset & (busy | st_acc);
  assign wr_idx  = busy ? cnt : idx;
  assign wr_word = busy ? '0 : merged;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE:    ;
      default: state_nxt = CLEAR;
    endcase
  end

  dm_load_ext u_ext (
    .word   (cur),
    .offset (add[1:0]),
    .op     (op),
    .result (ld_word)
  );

  // A rejected load still answers, with zero data, so the pipeline sees one rvalid per load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ld_acc;
      if (ld_acc) rdata <= err ? '0 : ld_word;
    end
  end

  logic unused;
`ifdef DM_WRITE_LOG_EN
  assign unused = ^off[1:0];
  always_ff @(posedge clk) begin
    if (~reset && st_acc) $display("@%h: *%h <= %h", pc, {add[31:2], 2'b00}, merged);
  end
`else
  assign unused = ^{pc, off[1:0]};
`endif
endmodule
